bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Countdown-timer mode for the digital watch: MM:SS held as packed BCD, decremented once per
//  tick enable down to 00:00, then alarm. Down-counting/borrow counterpart of the watch's
//  up-counting BCD carry chain. Sits beside the time-of-day chain; shares its tick and display mux.
// PARAMETERS
//  MAX_MIN     'h99  largest minute value accepted on load (packed BCD)
//  ALARM_TICKS 10    tick periods alarm stays high before self-clearing (1..255)
// PORTS
//  clk          in   1  system clock, single domain
//  reset        in   1  synchronous, active-high reset
//  tick         in   1  1-cycle count enable (1 Hz strobe); ignored unless RUN/ALARM
//  load         in   1  1-cycle: capture preset_min/preset_sec
//  preset_min   in   8  packed BCD minutes {tens,units}
//  preset_sec   in   8  packed BCD seconds {tens,units}
//  start        in   1  1-cycle: begin/resume countdown
//  stop         in   1  1-cycle: pause countdown / acknowledge alarm
//  min          out  8  current minutes, packed BCD
//  sec          out  8  current seconds, packed BCD
//  running      out  1  high while state==RUN
//  done         out  1  1-cycle pulse when count reaches 00:00
//  alarm        out  1  high in ALARM state
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high. All outputs registered.
//  - Reset: min=8'h00, sec=8'h00, state=IDLE, running=0, done=0, alarm=0.
//  - States IDLE, RUN, PAUSE, ALARM. Priority per cycle: reset > stop > load > start > tick.
//  - load (IDLE/PAUSE/ALARM): valid iff every nibble<=9, preset_sec<='h59, preset_min<=MAX_MIN.
//    Valid -> min/sec updated next cycle, state->IDLE, alarm cleared. Invalid -> ignored, no change.
//    load in RUN ignored.
//  - start: IDLE/PAUSE and {min,sec}!=0 -> RUN; if 00:00 stays put. Same cycle as load: load wins.
//  - stop: RUN->PAUSE (count frozen); ALARM->IDLE, alarm=0; else no effect. stop beats tick.
//  - RUN & tick: decrement. sec units 0->9 with borrow into sec tens; sec 00->59 with borrow
//    into min; min decrements likewise (units 0->9 borrow tens). Never decrement past 00:00.
//    Result visible one cycle after tick.
//  - Tick that produces 00:00: same update edge sets state=ALARM, done=1 for exactly one cycle,
//    alarm=1, running=0. E.g. 01:00 -tick-> 00:59; 00:01 -tick-> 00:00 + done.
//  - ALARM: 8-bit counter counts ticks; after ALARM_TICKS ticks -> IDLE, alarm=0. start in ALARM
//    ignored; stop/load acknowledge early as above.
//  - tick in IDLE/PAUSE: ignored. Reset mid-RUN/ALARM: everything to reset values next edge.
//  - Outputs never hold a non-BCD nibble.
// STRUCTURE
//  - Include file timer_defs.vh: state encodings (IDLE=2'd0,RUN=2'd1,PAUSE=2'd2,ALARM=2'd3),
//    BCD limit constants ('h9, 'h59).
//  - Sub-module bcd_down_counter (instantiated x2, sec and min): 2-digit BCD down counter with
//    parameter WRAPVAL ('h59 sec, 'h99 min), inputs clk/reset/bin/load/din, outputs data/bout
//    (bout=bin && data==0, combinational, so borrow ripples within one cycle).
//  - Top: FSM, load validation, alarm tick counter, zero detect, done pulse.
// TESTING
//  1 reset mid-count at 03:17 RUN -> next cycle min=00,sec=00,running=0,alarm=0,done=0.
//  2 load 02:00, start, 1 tick -> 01:59; 120 ticks total -> 00:00, done one cycle, alarm=1.
//  3 load 'h3A or sec='h60 -> ignored, previous value retained; load in RUN ignored.
//  4 RUN at 00:10, stop+tick same cycle -> PAUSE, 00:10 held; further ticks no change; start -> RUN.
//  5 start at 00:00 -> stays IDLE; load+start same cycle 00:05 -> IDLE, value 00:05.
//  6 ALARM: ALARM_TICKS=10 -> alarm drops after 10th tick; separate run: stop in ALARM -> immediate IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// State encodings, BCD limits and a nibble-validity helper.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'h9;
    localparam logic [7:0] SEC_MAX   = 8'h59;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= DIGIT_MAX) && (v[3:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the watch controller and the countdown timer.
// The controller drives strobes and presets; the timer returns count and status.
interface bcd_countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic       start;
    logic       stop;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       done;
    logic       alarm;

    modport master (
        output tick, load, preset_min, preset_sec, start, stop,
        input  min, sec, running, done, alarm
    );

    modport slave (
        input  tick, load, preset_min, preset_sec, start, stop,
        output min, sec, running, done, alarm
    );
endinterface

// File: rtl/bcd_countdown_timer_down.sv
// Two-digit packed-BCD down counter with wrap value and ripple borrow.
// bout is combinational so a borrow reaches the next digit pair in one cycle.
module bcd_down_counter #(
    parameter logic [7:0] WRAPVAL = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bin,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] data,
    output logic       bout
);

    assign bout = bin && (data == 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= 8'h00;
        end else if (load) begin
            data <= din;
        end else if (bin) begin
            if (data == 8'h00)
                data <= WRAPVAL;
            else if (data[3:0] == 4'h0)
                data <= {data[7:4] - 4'd1, 4'h9};
            else
                data <= {data[7:4], data[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: FSM, preset validation, zero detect and alarm timeout.
// Decrements once per tick while running; raises alarm on reaching 00:00.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter logic [7:0] MAX_MIN     = 8'h99,
    parameter int         ALARM_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_countdown_timer_if.slave bus
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t     state;
    logic [7:0] alarm_cnt;
    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic       sec_borrow;
    logic       min_borrow;
    logic       preset_ok;
    logic       load_ok;
    logic       nonzero;
    logic       at_one;
    logic       dec;

    assign preset_ok = bcd_ok(bus.preset_min) && bcd_ok(bus.preset_sec)
                    && (bus.preset_sec <= SEC_MAX)
                    && (bus.preset_min <= MAX_MIN);

    // stop outranks load; load is never honoured while running
    assign load_ok = bus.load && !bus.stop && (state != RUN) && preset_ok;
    assign nonzero = (min_q != 8'h00) || (sec_q != 8'h00);
    assign at_one  = (min_q == 8'h00) && (sec_q == 8'h01);
    assign dec     = (state == RUN) && bus.tick && !bus.stop && nonzero;

    bcd_down_counter #(.WRAPVAL(SEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .bin   (dec),
        .load  (load_ok),
        .din   (bus.preset_sec),
        .data  (sec_q),
        .bout  (sec_borrow)
    );

    bcd_down_counter #(.WRAPVAL(8'h99)) u_min (
        .clk   (clk),
        .reset (reset),
        .bin   (sec_borrow),
        .load  (load_ok),
        .din   (bus.preset_min),
        .data  (min_q),
        .bout  (min_borrow)
    );

    assign bus.min = min_q;
    assign bus.sec = sec_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alarm_cnt   <= 8'd0;
            bus.running <= 1'b0;
            bus.done    <= 1'b0;
            bus.alarm   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.stop) begin
                if (state == RUN) begin
                    state       <= PAUSE;
                    bus.running <= 1'b0;
                end else if (state == ALARM) begin
                    state     <= IDLE;
                    bus.alarm <= 1'b0;
                end
            end else if (bus.load && state != RUN) begin
                if (preset_ok) begin
                    state       <= IDLE;
                    bus.alarm   <= 1'b0;
                    bus.running <= 1'b0;
                end
            end else if (bus.start && (state == IDLE || state == PAUSE)
                         && nonzero) begin
                state       <= RUN;
                bus.running <= 1'b1;
            end else if (bus.tick) begin
                if (state == RUN && at_one) begin
                    state       <= ALARM;
                    bus.done    <= 1'b1;
                    bus.alarm   <= 1'b1;
                    bus.running <= 1'b0;
                    alarm_cnt   <= 8'd0;
                end else if (state == ALARM) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state     <= IDLE;
                        bus.alarm <= 1'b0;
                    end else begin
                        alarm_cnt <= alarm_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with hand-computed expectations.
module tb_bcd_countdown_timer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(.MAX_MIN(8'h99), .ALARM_TICKS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock edge, then sample 1ns later and drop single-cycle strobes
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        bus.preset_min = m;
        bus.preset_sec = s;
        bus.load       = 1'b1;
        cyc();
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0;
        bus.preset_min = 8'h00; bus.preset_sec = 8'h00;
        reset = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        check("rst_min", bus.min, 8'h00);
        check("rst_sec", bus.sec, 8'h00);
        check("rst_flags", {bus.running, bus.done, bus.alarm}, 3'b000);

        // reset mid-count at 03:17
        do_load(8'h03, 8'h17);
        do_start();
        check("t1_run", bus.running, 1'b1);
        do_tick();
        check("t1_dec", {bus.min, bus.sec}, 16'h0316);
        reset = 1'b1;
        cyc();
        check("t1_rst_val", {bus.min, bus.sec}, 16'h0000);
        check("t1_rst_flags", {bus.running, bus.done, bus.alarm}, 3'b000);

        // full countdown 02:00 -> 00:00, then alarm timeout
        do_load(8'h02, 8'h00);
        check("t2_load", {bus.min, bus.sec}, 16'h0200);
        do_start();
        do_tick();
        check("t2_first", {bus.min, bus.sec}, 16'h0159);
        do_tick();
        check("t2_second", {bus.min, bus.sec}, 16'h0158);
        for (int i = 0; i < 57; i++) do_tick();
        check("t2_one_min", {bus.min, bus.sec}, 16'h0101);
        do_tick();
        check("t2_100", {bus.min, bus.sec}, 16'h0100);
        do_tick();
        check("t2_059", {bus.min, bus.sec}, 16'h0059);
        for (int i = 0; i < 58; i++) do_tick();
        check("t2_001", {bus.min, bus.sec}, 16'h0001);
        check("t2_nodone", {bus.done, bus.alarm}, 2'b00);
        do_tick();
        check("t2_zero", {bus.min, bus.sec}, 16'h0000);
        check("t2_flags", {bus.running, bus.done, bus.alarm}, 3'b011);
        cyc();
        check("t2_done_pulse", bus.done, 1'b0);
        check("t2_alarm_hold", bus.alarm, 1'b1);
        do_start();
        check("t6_start_ign", {bus.running, bus.alarm}, 2'b01);
        for (int i = 0; i < 9; i++) do_tick();
        check("t6_alarm_9", bus.alarm, 1'b1);
        do_tick();
        check("t6_alarm_10", bus.alarm, 1'b0);
        check("t6_hold_zero", {bus.min, bus.sec}, 16'h0000);

        // invalid presets ignored, load in RUN ignored
        do_load(8'h05, 8'h30);
        check("t3_valid", {bus.min, bus.sec}, 16'h0530);
        do_load(8'h3A, 8'h10);
        check("t3_bad_min", {bus.min, bus.sec}, 16'h0530);
        do_load(8'h01, 8'h60);
        check("t3_bad_sec", {bus.min, bus.sec}, 16'h0530);
        do_start();
        do_load(8'h01, 8'h00);
        check("t3_run_load", {bus.min, bus.sec, 7'd0, bus.running},
              {16'h0530, 8'h01});

        // stop beats tick; pause holds; resume
        bus.stop = 1'b1;
        cyc();
        do_load(8'h00, 8'h10);
        do_start();
        bus.stop = 1'b1;
        bus.tick = 1'b1;
        cyc();
        check("t4_pause", {bus.min, bus.sec, 7'd0, bus.running},
              {16'h0010, 8'h00});
        do_tick();
        do_tick();
        check("t4_hold", {bus.min, bus.sec}, 16'h0010);
        do_start();
        check("t4_resume", bus.running, 1'b1);
        do_tick();
        check("t4_dec", {bus.min, bus.sec}, 16'h0009);

        // start at zero, load+start same cycle
        reset = 1'b1;
        cyc();
        do_start();
        check("t5_zero_start", bus.running, 1'b0);
        bus.preset_min = 8'h00;
        bus.preset_sec = 8'h05;
        bus.load  = 1'b1;
        bus.start = 1'b1;
        cyc();
        check("t5_load_wins", {bus.min, bus.sec, 7'd0, bus.running},
              {16'h0005, 8'h00});

        // stop acknowledges alarm immediately
        do_load(8'h00, 8'h01);
        do_start();
        do_tick();
        check("t6b_alarm", {bus.alarm, bus.done}, 2'b11);
        bus.stop = 1'b1;
        cyc();
        check("t6b_ack", {bus.alarm, bus.running}, 2'b00);
        do_start();
        check("t6b_idle", bus.running, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
